cpu_test_sequencer: RTL and testbench



---
 rtl/cpu_test_sequencer_pkg.sv | 26 ++
 rtl/cpu_test_sequencer_word_counter.sv | 36 +++
 rtl/cpu_test_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_cpu_test_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_test_sequencer_pkg.sv
// Shared state encoding, address strides and count helper for the cpu test sequencer.
package cpu_test_sequencer_pkg;

    localparam int unsigned IMEM_STRIDE = 4;
    localparam int unsigned DMEM_STRIDE = 8;
    localparam int unsigned IDX_W       = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_I,
        S_LOAD_D,
        S_RUN,
        S_DUMP_REQ,
        S_DUMP_CAP,
        S_DUMP_OUT,
        S_DONE
    } state_t;

    // Clamp a requested word count to the memory depth.
    function automatic logic [IDX_W-1:0] sat_count(input logic [7:0] n, input int unsigned depth);
        logic [IDX_W-1:0] d;
        d = IDX_W'(depth);
        return (IDX_W'(n) > d) ? d : IDX_W'(n);
    endfunction

endpackage

// File: rtl/cpu_test_sequencer_word_counter.sv
// seq_word_counter: loadable down-counter with an up-counting index and zero/last flags.
module seq_word_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic [W-1:0] index,
    output logic         zero_c,
    output logic         last_c
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
            index <= '0;
        end else if (clr) begin
            count <= '0;
            index <= '0;
        end else if (load) begin
            count <= load_val;
            index <= '0;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
            index <= index + W'(1);
        end
    end

    assign zero_c = (count == '0);
    assign last_c = (count == W'(1));

endmodule

// File: rtl/cpu_test_sequencer.sv
// Test-run sequencer: streams imem/dmem images in, runs the cpu for a set cycle count, dumps dmem out.
module cpu_test_sequencer
    import cpu_test_sequencer_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 128,
    parameter int unsigned DMEM_DEPTH = 128,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic [7:0]       imem_words,
    input  logic [7:0]       dmem_words,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             enable,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2,
    output logic             busy,
    output logic             done
);

    state_t state, state_nx;
    state_t start_nx, after_li, after_ld, after_run;

    logic [IDX_W-1:0] st_imem, st_dmem;
    logic             accept;

    logic             ld_load, ld_dec, ld_zero, ld_last;
    logic [IDX_W-1:0] ld_val, ld_index, unused_ld_count;
    logic             run_load, run_dec, run_zero, unused_run_last;
    logic [CNT_W-1:0] unused_run_count, unused_run_index;
    logic             dp_load, dp_dec, dp_zero, dp_last;
    logic [IDX_W-1:0] dp_count, dp_index;

    logic        enable_nx, wen_nx, wen2_nx, ren2_nx, out_valid_nx;
    logic [63:0] addr_nx, addr2_nx, wdata2_nx, out_data_nx;
    logic [31:0] wdata_nx;

    // Load counter serves imem then dmem; dump counter also holds the dmem count until the dump.
    seq_word_counter #(.W(IDX_W)) u_load_cnt (
        .clk(clk), .arst_n(arst_n), .clr(abort), .load(ld_load), .load_val(ld_val), .dec(ld_dec),
        .count(unused_ld_count), .index(ld_index), .zero_c(ld_zero), .last_c(ld_last)
    );

    seq_word_counter #(.W(CNT_W)) u_run_cnt (
        .clk(clk), .arst_n(arst_n), .clr(abort), .load(run_load), .load_val(run_cycles), .dec(run_dec),
        .count(unused_run_count), .index(unused_run_index), .zero_c(run_zero), .last_c(unused_run_last)
    );

    seq_word_counter #(.W(IDX_W)) u_dump_cnt (
        .clk(clk), .arst_n(arst_n), .clr(abort), .load(dp_load), .load_val(st_dmem), .dec(dp_dec),
        .count(dp_count), .index(dp_index), .zero_c(dp_zero), .last_c(dp_last)
    );

    assign st_imem  = sat_count(imem_words, IMEM_DEPTH);
    assign st_dmem  = sat_count(dmem_words, DMEM_DEPTH);
    assign in_ready = ((state == S_LOAD_I) || (state == S_LOAD_D)) && !ld_zero;
    assign accept   = in_valid && in_ready;
    assign ren_ext  = 1'b0;

    // Phase-skip chain: every stage whose count is zero is bypassed in the same transition.
    always_comb begin
        after_run = dp_zero ? S_DONE : S_DUMP_REQ;
        after_ld  = run_zero ? after_run : S_RUN;
        after_li  = dp_zero ? after_ld : S_LOAD_D;
        if (st_imem != '0)             start_nx = S_LOAD_I;
        else if (st_dmem != '0)        start_nx = S_LOAD_D;
        else if (run_cycles != '0)     start_nx = S_RUN;
        else                           start_nx = S_DONE;
    end

    always_comb begin
        state_nx     = state;
        enable_nx    = 1'b0;
        wen_nx       = 1'b0;
        wen2_nx      = 1'b0;
        ren2_nx      = 1'b0;
        out_valid_nx = 1'b0;
        addr_nx      = addr_ext;
        wdata_nx     = wdata_ext;
        addr2_nx     = addr_ext_2;
        wdata2_nx    = wdata_ext_2;
        out_data_nx  = out_data;
        ld_load      = 1'b0;
        ld_val       = dp_count;
        ld_dec       = 1'b0;
        run_load     = 1'b0;
        run_dec      = 1'b0;
        dp_load      = 1'b0;
        dp_dec       = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nx = start_nx;
                    ld_load  = 1'b1;
                    ld_val   = (st_imem != '0) ? st_imem : st_dmem;
                    run_load = 1'b1;
                    dp_load  = 1'b1;
                end
            end
            S_LOAD_I: begin
                if (accept) begin
                    wen_nx   = 1'b1;
                    addr_nx  = 64'(IMEM_STRIDE) * 64'(ld_index);
                    wdata_nx = in_data[31:0];
                    ld_dec   = 1'b1;
                    if (ld_last) begin
                        state_nx = after_li;
                        ld_load  = 1'b1;
                    end
                end
            end
            S_LOAD_D: begin
                if (accept) begin
                    wen2_nx   = 1'b1;
                    addr2_nx  = 64'(DMEM_STRIDE) * 64'(ld_index);
                    wdata2_nx = in_data;
                    ld_dec    = 1'b1;
                    if (ld_last) state_nx = after_ld;
                end
            end
            // First RUN cycle lets the final load strobe retire before enable rises.
            S_RUN: begin
                if (!run_zero) begin
                    enable_nx = 1'b1;
                    run_dec   = 1'b1;
                end else begin
                    state_nx = after_run;
                end
            end
            S_DUMP_REQ: begin
                if (ren_ext_2) begin
                    state_nx = S_DUMP_CAP;
                end else begin
                    ren2_nx  = 1'b1;
                    addr2_nx = 64'(DMEM_STRIDE) * 64'(dp_index);
                end
            end
            S_DUMP_CAP: begin
                out_data_nx  = rdata_ext_2;
                out_valid_nx = 1'b1;
                state_nx     = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                out_valid_nx = 1'b1;
                if (out_valid && out_ready) begin
                    out_valid_nx = 1'b0;
                    dp_dec       = 1'b1;
                    state_nx     = dp_last ? S_DONE : S_DUMP_REQ;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (abort) begin
            state_nx     = S_IDLE;
            enable_nx    = 1'b0;
            wen_nx       = 1'b0;
            wen2_nx      = 1'b0;
            ren2_nx      = 1'b0;
            out_valid_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            enable      <= 1'b0;
            wen_ext     <= 1'b0;
            addr_ext    <= '0;
            wdata_ext   <= '0;
            wen_ext_2   <= 1'b0;
            ren_ext_2   <= 1'b0;
            addr_ext_2  <= '0;
            wdata_ext_2 <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            enable      <= enable_nx;
            wen_ext     <= wen_nx;
            addr_ext    <= addr_nx;
            wdata_ext   <= wdata_nx;
            wen_ext_2   <= wen2_nx;
            ren_ext_2   <= ren2_nx;
            addr_ext_2  <= addr2_nx;
            wdata_ext_2 <= wdata2_nx;
            out_valid   <= out_valid_nx;
            out_data    <= out_data_nx;
            busy        <= (state_nx != S_IDLE) && (state_nx != S_DONE);
            done        <= (state_nx == S_DONE);
        end
    end

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Randomized bench for cpu_test_sequencer: dmem environment, transaction monitor and a stream-level model.
module tb_cpu_test_sequencer;

    logic        clk = 1'b0;
    logic        arst_n, start, abort, in_valid, in_ready, out_valid, out_ready;
    logic        enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2, busy, done;
    logic [7:0]  imem_words, dmem_words;
    logic [31:0] run_cycles, wdata_ext;
    logic [63:0] in_data, out_data, addr_ext, addr_ext_2, wdata_ext_2;
    logic [63:0] rdata_ext_2 = 64'h0;

    always #5 clk = ~clk;

    cpu_test_sequencer #(.IMEM_DEPTH(128), .DMEM_DEPTH(128), .CNT_W(32)) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .imem_words(imem_words), .dmem_words(dmem_words),
        .run_cycles(run_cycles), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .enable(enable), .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
        .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .busy(busy), .done(done)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] init_word(input int i);
        return {32'(i) * 32'h9e37_79b9, 32'hc0de_0000 | 32'(i)};
    endfunction

    // Data memory behind the DUT: registered read, one cycle after ren_ext_2.
    logic [63:0] dmem [128];
    bit          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 128; i++) dmem[i] <= init_word(i);
            mem_init <= 1'b1;
        end else begin
            if (wen_ext_2) dmem[addr_ext_2[9:3]] <= wdata_ext_2;
            if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[9:3]];
        end
    end

    // Transaction monitor, sampled mid-cycle.
    logic [63:0] iw_a[$], iw_d[$], dw_a[$], dw_d[$], outs[$];
    int          en_cycles, en_rises, ren_cnt, viol, acc_cnt, cyc, last_wen_cyc, first_en_cyc;
    bit          en_prev, stall_prev, acc_flag;
    logic [63:0] stall_data;
    initial begin
        cyc = 0; en_prev = 0; stall_prev = 0; acc_flag = 0; stall_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            acc_flag = in_valid && in_ready;
            if (acc_flag) acc_cnt++;
            if (wen_ext) begin iw_a.push_back(addr_ext); iw_d.push_back({32'h0, wdata_ext}); end
            if (wen_ext_2) begin dw_a.push_back(addr_ext_2); dw_d.push_back(wdata_ext_2); end
            if (wen_ext || wen_ext_2) last_wen_cyc = cyc;
            if (enable) en_cycles++;
            if (enable && !en_prev) begin
                en_rises++;
                if (first_en_cyc < 0) first_en_cyc = cyc;
            end
            en_prev = enable;
            if (ren_ext_2) ren_cnt++;
            if (enable && (wen_ext || wen_ext_2 || !busy)) viol++;
            if (ren_ext_2 && wen_ext_2) viol++;
            if (done && busy) viol++;
            if (stall_prev && (!out_valid || out_data !== stall_data)) viol++;
            if (out_valid && out_ready) outs.push_back(out_data);
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    // Stream drivers: load beats from feed_q, dump backpressure by mode.
    logic [63:0] feed_q[$];
    int          vpat = 0, omode = 0, held = 0;
    bit          tog = 0;
    initial begin
        in_valid = 0; in_data = '0; out_ready = 0;
        forever begin
            @(posedge clk); #1;
            if (acc_flag && feed_q.size() > 0) feed_q.delete(0);
            tog = !tog;
            in_data = (feed_q.size() > 0) ? feed_q[0] : 64'h0;
            case (vpat)
                0:       in_valid = feed_q.size() > 0;
                1:       in_valid = feed_q.size() > 0 && tog;
                default: in_valid = feed_q.size() > 0 && ($urandom_range(1) == 1);
            endcase
            if (outs.size() == 0) held = 0;
            if (omode == 2 && out_valid && outs.size() == 1 && held < 5) begin
                out_ready = 0;
                held++;
            end else if (omode == 1) out_ready = ($urandom_range(2) != 0);
            else out_ready = 1;
        end
    end

    logic [63:0] shadow [128];
    logic [63:0] fixed_beats[$];

    task automatic clear_monitor();
        iw_a.delete(); iw_d.delete(); dw_a.delete(); dw_d.delete(); outs.delete();
        en_cycles = 0; en_rises = 0; ren_cnt = 0; viol = 0; acc_cnt = 0;
        last_wen_cyc = -1; first_en_cyc = -1;
    endtask

    task automatic pulse_start(input int ni, input int nd, input int nr);
        @(posedge clk); #1;
        start = 1; imem_words = 8'(ni); dmem_words = 8'(nd); run_cycles = 32'(nr);
        @(posedge clk); #1;
        start = 0; imem_words = 8'($urandom); dmem_words = 8'($urandom); run_cycles = $urandom;
    endtask

    task automatic run_test(input int ni, input int nd, input int nr, input int vp, input int om,
                            input bit busy_start);
        int si, sd, n;
        logic [63:0] beats[$];
        si = (ni > 128) ? 128 : ni;
        sd = (nd > 128) ? 128 : nd;
        n  = si + sd;
        for (int i = 0; i < n; i++)
            beats.push_back((i < fixed_beats.size()) ? fixed_beats[i] : {$urandom, $urandom});
        clear_monitor();
        vpat = vp; omode = om; feed_q = beats;
        pulse_start(ni, nd, nr);
        if (busy_start) begin
            for (int k = 0; k < 500 && !enable; k++) @(negedge clk);
            pulse_start(5, 5, 3);
        end
        for (int k = 0; k < 5000 && !done; k++) @(negedge clk);
        check("done", 64'(done), 64'(1));
        repeat (3) @(negedge clk);
        check("iw_count", 64'(iw_a.size()), 64'(si));
        for (int i = 0; i < si && i < iw_a.size(); i++) begin
            check("iw_addr", iw_a[i], 64'(4 * i));
            check("iw_data", iw_d[i], {32'h0, beats[i][31:0]});
        end
        check("dw_count", 64'(dw_a.size()), 64'(sd));
        for (int j = 0; j < sd; j++) begin
            shadow[j] = beats[si + j];
            if (j < dw_a.size()) begin
                check("dw_addr", dw_a[j], 64'(8 * j));
                check("dw_data", dw_d[j], beats[si + j]);
            end
        end
        check("en_cycles", 64'(en_cycles), 64'(nr));
        check("en_rises", 64'(en_rises), 64'(nr > 0));
        if (nr > 0 && n > 0) check("en_after_strobe", 64'(first_en_cyc - last_wen_cyc), 64'(1));
        check("ren_pulses", 64'(ren_cnt), 64'(sd));
        check("out_count", 64'(outs.size()), 64'(sd));
        for (int j = 0; j < sd && j < outs.size(); j++) check("out_data", outs[j], shadow[j]);
        if (om == 2 && sd > 1) check("stall_cycles", 64'(held), 64'(5));
        check("protocol", 64'(viol), 64'(0));
        check("busy_in_done", 64'(busy), 64'(0));
        feed_q.delete();
        fixed_beats.delete();
    endtask

    initial begin
        arst_n = 0; start = 0; abort = 0;
        imem_words = '0; dmem_words = '0; run_cycles = '0;
        for (int i = 0; i < 128; i++) shadow[i] = init_word(i);
        repeat (3) @(negedge clk);
        arst_n = 1;
        @(negedge clk);
        check("rst_enable", 64'(enable), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_strobes", 64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'(0));
        check("rst_addr", addr_ext | addr_ext_2, 64'(0));
        check("rst_out_data", out_data, 64'(0));

        // Short program, no dmem, no run.
        fixed_beats = '{64'h0000_0000_0050_0093, 64'h0000_0000_0010_0113, 64'h0000_0000_0020_81b3};
        run_test(3, 0, 0, 0, 0, 0);
        // Full flow with an ignored start while running.
        run_test(1, 2, 10, 0, 0, 1);
        // Dump backpressure on word 1.
        run_test(0, 3, 4, 0, 2, 0);
        // in_valid toggling during dmem load.
        run_test(0, 4, 0, 1, 1, 0);

        // Abort after two of four dmem beats.
        clear_monitor();
        vpat = 0; omode = 0;
        fixed_beats = '{{$urandom, $urandom}, {$urandom, $urandom}};
        feed_q = fixed_beats;
        pulse_start(0, 4, 5);
        for (int k = 0; k < 200 && acc_cnt < 2; k++) @(negedge clk);
        @(posedge clk); #1; abort = 1;
        @(posedge clk); #1; abort = 0;
        @(negedge clk);
        check("abort_in_ready", 64'(in_ready), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        repeat (10) @(negedge clk);
        check("abort_writes", 64'(dw_a.size()), 64'(2));
        check("abort_enable", 64'(en_cycles), 64'(0));
        for (int j = 0; j < 2; j++) shadow[j] = fixed_beats[j];
        fixed_beats.delete();
        feed_q.delete();

        // imem count above depth saturates.
        run_test(200, 0, 0, 2, 0, 0);

        // Asynchronous reset while running.
        clear_monitor();
        pulse_start(0, 0, 50);
        for (int k = 0; k < 100 && !enable; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        @(posedge clk); #2; arst_n = 0; #1;
        check("mid_rst_enable", 64'(enable), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_strobes", 64'({wen_ext, wen_ext_2, ren_ext_2, in_ready}), 64'(0));
        @(posedge clk); #1; arst_n = 1;

        run_test(2, 3, 6, 0, 1, 0);
        for (int t = 0; t < 6; t++)
            run_test($urandom_range(6), $urandom_range(6), $urandom_range(20), $urandom_range(2), 1, 0);
        run_test(0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
